// File: rtl/oserdes_gen.sv
// oserdes_gen - generic fabric output serializer for the AFE link transmit path.
//
// Accepts one parallel word per lane over a valid/ready handshake, buffers at
// most one word, and shifts it out one bit per clock in fixed RATIO-cycle slots.
// The slots are aligned to reset release. Any slot without data carries
// IDLE_PATTERN.
//
// Parameters:
//   WIDTH        number of lanes
//   RATIO        bits per word per lane (2..32)
//   MSB_FIRST    1: bit RATIO-1 is sent first, 0: bit 0 is sent first
//   IDLE_PATTERN word sent on every lane in idle slots (same bit order as data)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   s_data   parallel words; lane n is s_data[n*RATIO +: RATIO]
//   s_valid  s_data is valid
//   s_ready  a word can be accepted (registered)
//   q        serial bit per lane (registered)
//   frame    high during the first bit of a data slot
//   underrun one-cycle pulse on the first bit of an idle slot that follows a data slot
//   busy     a data slot is on q or a word is waiting in the hold register
module oserdes_gen #(
    parameter int                WIDTH        = 1,
    parameter int                RATIO        = 8,
    parameter int                MSB_FIRST    = 1,
    parameter logic [RATIO-1:0]  IDLE_PATTERN = {RATIO{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH*RATIO-1:0]   s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     frame,
    output logic                     underrun,
    output logic                     busy
);

    localparam int               CW   = $clog2(RATIO);
    localparam logic [CW-1:0]    LAST = CW'(RATIO - 1);

    // First bit of a word in transmit order.
    function automatic logic first_bit(input logic [RATIO-1:0] word);
        if (MSB_FIRST != 0) begin
            return word[RATIO-1];
        end else begin
            return word[0];
        end
    endfunction

    // Drops the bit just sent so the next bit sits in the first-bit position.
    function automatic logic [RATIO-1:0] advance(input logic [RATIO-1:0] word);
        if (MSB_FIRST != 0) begin
            return {word[RATIO-2:0], 1'b0};
        end else begin
            return {1'b0, word[RATIO-1:1]};
        end
    endfunction

    logic [CW-1:0]                  r_cnt;
    logic [WIDTH*RATIO-1:0]         r_hold;
    logic                           r_hold_valid;
    logic                           r_s_ready;
    logic [WIDTH-1:0][RATIO-1:0]    r_shift;
    logic [WIDTH-1:0]               r_q;
    logic                           r_frame;
    logic                           r_underrun;
    logic                           r_busy;
    logic                           r_last_was_data;
    logic                           r_slot_data;

    logic                           w_boundary;
    logic                           w_xfer;
    logic                           w_load_data;
    logic [CW-1:0]                  w_cnt_nxt;
    logic                           w_hold_valid_nxt;
    logic                           w_slot_data_nxt;
    logic                           w_last_was_data_nxt;
    logic                           w_frame_nxt;
    logic                           w_underrun_nxt;
    logic                           w_busy_nxt;
    logic [WIDTH-1:0][RATIO-1:0]    w_lane_word;
    logic [WIDTH-1:0][RATIO-1:0]    w_shift_nxt;
    logic [WIDTH-1:0]               w_q_nxt;

    // Slot timing, handshake and status next-state logic.
    always_comb begin
        w_boundary          = (r_cnt == LAST);
        w_xfer              = s_valid & r_s_ready;
        w_load_data         = w_boundary & r_hold_valid;
        w_frame_nxt         = w_load_data;
        // Underrun only when an idle slot directly follows a data slot.
        w_underrun_nxt      = w_boundary & ~r_hold_valid & r_last_was_data;

        if (w_boundary) begin
            w_cnt_nxt           = {CW{1'b0}};
            w_slot_data_nxt     = r_hold_valid;
            w_last_was_data_nxt = r_hold_valid;
        end else begin
            w_cnt_nxt           = r_cnt + CW'(1);
            w_slot_data_nxt     = r_slot_data;
            w_last_was_data_nxt = r_last_was_data;
        end

        // A transfer is only possible while the hold register is empty, so it
        // can never coincide with the hold word moving into the slot; a
        // transfer on the boundary edge therefore waits for the next boundary.
        if (w_xfer) begin
            w_hold_valid_nxt = 1'b1;
        end else if (w_load_data) begin
            w_hold_valid_nxt = 1'b0;
        end else begin
            w_hold_valid_nxt = r_hold_valid;
        end

        w_busy_nxt = w_hold_valid_nxt | w_slot_data_nxt;
    end

    // Per-lane serializer: q carries the current bit, r_shift the bits still to go.
    always_comb begin
        w_lane_word = {(WIDTH*RATIO){1'b0}};
        w_shift_nxt = {(WIDTH*RATIO){1'b0}};
        w_q_nxt     = {WIDTH{1'b0}};
        for (int n = 0; n < WIDTH; n++) begin
            if (w_load_data) begin
                w_lane_word[n] = r_hold[n*RATIO +: RATIO];
            end else begin
                w_lane_word[n] = IDLE_PATTERN;
            end
            if (w_boundary) begin
                w_q_nxt[n]     = first_bit(w_lane_word[n]);
                w_shift_nxt[n] = advance(w_lane_word[n]);
            end else begin
                w_q_nxt[n]     = first_bit(r_shift[n]);
                w_shift_nxt[n] = advance(r_shift[n]);
            end
        end
    end

    // State and output registers; reset starts an idle slot at cnt=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= {CW{1'b0}};
            r_hold_valid    <= 1'b0;
            r_s_ready       <= 1'b1;
            r_frame         <= 1'b0;
            r_underrun      <= 1'b0;
            r_busy          <= 1'b0;
            r_last_was_data <= 1'b0;
            r_slot_data     <= 1'b0;
            // q already shows the first idle bit, so the shifter holds the rest.
            for (int n = 0; n < WIDTH; n++) begin
                r_shift[n] <= advance(IDLE_PATTERN);
                r_q[n]     <= first_bit(IDLE_PATTERN);
            end
        end else begin
            r_cnt           <= w_cnt_nxt;
            r_hold_valid    <= w_hold_valid_nxt;
            r_s_ready       <= ~w_hold_valid_nxt;
            r_frame         <= w_frame_nxt;
            r_underrun      <= w_underrun_nxt;
            r_busy          <= w_busy_nxt;
            r_last_was_data <= w_last_was_data_nxt;
            r_slot_data     <= w_slot_data_nxt;
            r_shift         <= w_shift_nxt;
            r_q             <= w_q_nxt;
        end
    end

    // Hold register captures the word on each accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= {(WIDTH*RATIO){1'b0}};
        end else if (w_xfer) begin
            r_hold <= s_data;
        end else begin
            r_hold <= r_hold;
        end
    end

    assign s_ready  = r_s_ready;
    assign q        = r_q;
    assign frame    = r_frame;
    assign underrun = r_underrun;
    assign busy     = r_busy;

endmodule
